uart_tx: RTL and testbench

Serializing UART transmitter feeding the `uart_rx` stage on the serial side.
- Accepts one W_IN-bit parallel word over a valid/ready handshake.
- Transmits it as NUM_WORDS consecutive UART packets.
- Each packet is 1 start bit (0), BITS_PER_WORD data bits LSB first, and 1 stop bit (1), every bit held CLOCKS_PER_PULSE clocks.
- Word order matches `uart_rx` reassembly, so `uart_tx -> uart_rx` loopback returns the original W_IN-bit value on `m_data`.

---
 rtl/uart_tx.sv | 111 +++++++++++
 tb/tb_uart_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: one W_IN-bit handshake word goes out as NUM_WORDS 8N1-style
// packets, lowest word first, each bit held CLOCKS_PER_PULSE clocks.
module uart_tx #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int W_IN             = 16,
  parameter int BITS_PER_WORD    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  input  logic [W_IN-1:0] s_data,
  output logic            s_ready,
  output logic            tx
);
  localparam int NUM_WORDS = W_IN / BITS_PER_WORD;
  localparam int PW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int BW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BITS_PER_WORD - 1);
  localparam logic [WW-1:0] W_LAST = WW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   pulse_cnt, pulse_n;
  logic [BW-1:0]   bit_cnt, bit_n;
  logic [WW-1:0]   word_cnt, word_n;
  logic [W_IN-1:0] hold, hold_n;
  logic            tx_n;
  logic            wrap;

  assign s_ready = !rst && (state == IDLE);
  assign wrap    = (pulse_cnt == P_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pulse_cnt <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      hold      <= '0;
      tx        <= 1'b1;
    end else begin
      state     <= state_n;
      pulse_cnt <= pulse_n;
      bit_cnt   <= bit_n;
      word_cnt  <= word_n;
      hold      <= hold_n;
      tx        <= tx_n;
    end
  end

  // tx is registered from the next-state decision so the line level lines up
  // with the state it belongs to, starting on the handshake edge itself.
  always_comb begin
    state_n = state;
    pulse_n = pulse_cnt;
    bit_n   = bit_cnt;
    word_n  = word_cnt;
    hold_n  = hold;
    tx_n    = tx;
    if (state != IDLE)
      pulse_n = wrap ? '0 : pulse_cnt + 1'b1;
    case (state)
      IDLE: begin
        if (s_valid) begin
          state_n = START;
          hold_n  = s_data;
          pulse_n = '0;
          bit_n   = '0;
          word_n  = '0;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (wrap) begin
          state_n = DATA;
          tx_n    = hold[0];
        end
      end
      DATA: begin
        if (wrap) begin
          // hold shifts one bit per data bit, so bit 0 is always the next to send
          hold_n = hold >> 1;
          if (bit_cnt == B_LAST) begin
            state_n = STOP;
            bit_n   = '0;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_cnt + 1'b1;
            tx_n  = hold_n[0];
          end
        end
      end
      STOP: begin
        if (wrap) begin
          if (word_cnt == W_LAST) begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end else begin
            state_n = START;
            word_n  = word_cnt + 1'b1;
            tx_n    = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: default instance plus a CLOCKS_PER_PULSE=1, 8-bit corner
// instance, checked against an arithmetic line model and a sampling receiver.
module tb_uart_tx;
  localparam int CPP = 4, BPW = 8, WIN = 16, NW = WIN / BPW;
  localparam int F   = NW * (BPW + 2) * CPP;
  localparam int FB  = 10;

  logic clk = 1'b0, rst = 1'b1;
  logic s_valid = 1'b0, s_ready, tx;
  logic [WIN-1:0] s_data = '0;
  logic s_valid_b = 1'b0, s_ready_b, tx_b;
  logic [7:0] s_data_b = '0;

  int nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLOCKS_PER_PULSE(CPP), .W_IN(WIN), .BITS_PER_WORD(BPW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .tx(tx));

  uart_tx #(.CLOCKS_PER_PULSE(1), .W_IN(8), .BITS_PER_WORD(8)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid_b), .s_data(s_data_b),
    .s_ready(s_ready_b), .tx(tx_b));

  // Expected line level k cycles after the handshake edge.
  function automatic logic exp_tx(input logic [31:0] d, input int k, input int cpp, input int bpw);
    int slot, p, w;
    slot = k / cpp;
    p    = slot % (bpw + 2);
    w    = slot / (bpw + 2);
    if (p == 0) return 1'b0;
    if (p == bpw + 1) return 1'b1;
    return d[w * bpw + p - 1];
  endfunction

  // Independent receiver: mid-bit sampling, packets reassembled low word first.
  logic rx_en = 1'b0;
  logic [WIN-1:0] rx_q[$];
  int rx_bad_stop = 0;
  initial begin
    logic [WIN-1:0] acc;
    logic [BPW-1:0] by;
    int pk;
    acc = '0; pk = 0;
    forever begin
      @(negedge clk);
      if (!rx_en) begin
        pk = 0; acc = '0;
      end else if (tx === 1'b0) begin
        repeat (CPP + CPP / 2) @(negedge clk);
        for (int b = 0; b < BPW; b++) begin
          by[b] = tx;
          if (b < BPW - 1) repeat (CPP) @(negedge clk);
        end
        repeat (CPP) @(negedge clk);
        if (tx !== 1'b1) rx_bad_stop++;
        acc[pk * BPW +: BPW] = by;
        pk++;
        if (pk == NW) begin
          rx_q.push_back(acc);
          pk = 0; acc = '0;
        end
      end
    end
  end

  task automatic hs_a(input logic [WIN-1:0] d);
    int n = 0;
    s_data = d; s_valid = 1'b1;
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    nchk++;
    if (n >= 200) begin nerr++; $display("FAIL hs_timeout: s_ready=%b required 1", s_ready); end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Entered on the negedge of cycle 0 of a frame, leaves on the negedge of cycle F.
  task automatic check_frame_a(input logic [WIN-1:0] d, input bit noisy, input string nm);
    logic e;
    for (int k = 0; k < F; k++) begin
      e = exp_tx({16'h0, d}, k, CPP, BPW);
      nchk++;
      if (tx !== e || s_ready !== 1'b0) begin
        nerr++;
        $display("FAIL %s k=%0d: tx=%b s_ready=%b required tx=%b s_ready=0", nm, k, tx, s_ready, e);
      end
      if (noisy) begin s_valid = 1'b1; s_data = 16'($urandom); end
      @(negedge clk);
    end
    nchk++;
    if (tx !== 1'b1 || s_ready !== 1'b1) begin
      nerr++;
      $display("FAIL %s end: tx=%b s_ready=%b required tx=1 s_ready=1", nm, tx, s_ready);
    end
    if (noisy) s_valid = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nchk++;
      if (tx !== 1'b1 || s_ready !== 1'b0 || tx_b !== 1'b1 || s_ready_b !== 1'b0) begin
        nerr++;
        $display("FAIL reset: tx=%b s_ready=%b tx_b=%b s_ready_b=%b required 1 0 1 0", tx, s_ready, tx_b, s_ready_b);
      end
    end
    rst = 1'b0; #1;
    nchk++;
    if (s_ready !== 1'b1 || s_ready_b !== 1'b1) begin
      nerr++; $display("FAIL reset_release: s_ready=%b s_ready_b=%b required 1 1", s_ready, s_ready_b);
    end
  endtask

  task automatic test_single;
    hs_a(16'hA53C);
    check_frame_a(16'hA53C, 1'b0, "single");
  endtask

  task automatic test_back_to_back;
    s_data = 16'h0001; s_valid = 1'b1;
    @(negedge clk);
    s_data = 16'hFFFF;
    check_frame_a(16'h0001, 1'b0, "b2b_first");
    @(negedge clk);
    s_valid = 1'b0;
    check_frame_a(16'hFFFF, 1'b0, "b2b_second");
  endtask

  task automatic test_busy_ignore;
    logic [WIN-1:0] d;
    d = 16'($urandom);
    hs_a(d);
    check_frame_a(d, 1'b1, "busy_ignore");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      nchk++;
      if (tx !== 1'b1 || s_ready !== 1'b1) begin
        nerr++; $display("FAIL busy_extra_frame i=%0d: tx=%b s_ready=%b required 1 1", i, tx, s_ready);
      end
    end
  endtask

  task automatic test_reset_mid;
    hs_a(16'h00FF);
    repeat (30) @(negedge clk);
    rst = 1'b1; #1;
    nchk++;
    if (s_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready: s_ready=%b required 0", s_ready); end
    @(negedge clk);
    nchk++;
    if (tx !== 1'b1 || s_ready !== 1'b0) begin
      nerr++; $display("FAIL rst_mid: tx=%b s_ready=%b required 1 0", tx, s_ready);
    end
    rst = 1'b0; #1;
    nchk++;
    if (s_ready !== 1'b1 || tx !== 1'b1) begin
      nerr++; $display("FAIL rst_release: s_ready=%b tx=%b required 1 1", s_ready, tx);
    end
    hs_a(16'h1234);
    check_frame_a(16'h1234, 1'b0, "after_rst");
    rst = 1'b1; s_valid = 1'b1; s_data = 16'hBEEF;
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      nchk++;
      if (tx !== 1'b1 || s_ready !== 1'b1) begin
        nerr++; $display("FAIL rst_vs_valid i=%0d: tx=%b s_ready=%b required 1 1", i, tx, s_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_corner;
    logic [7:0] d;
    logic [9:0] tbl;
    logic e;
    int n;
    d = 8'h81;
    tbl = 10'b1100000010;  // bit k is the level in cycle k
    n = 0;
    s_data_b = d; s_valid_b = 1'b1;
    while (!s_ready_b && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    s_valid_b = 1'b0;
    for (int k = 0; k < FB; k++) begin
      e = exp_tx({24'h0, d}, k, 1, 8);
      nchk++;
      if (tx_b !== e || tx_b !== tbl[k] || s_ready_b !== 1'b0) begin
        nerr++;
        $display("FAIL corner k=%0d: tx_b=%b s_ready_b=%b required tx_b=%b s_ready_b=0", k, tx_b, s_ready_b, tbl[k]);
      end
      @(negedge clk);
    end
    nchk++;
    if (tx_b !== 1'b1 || s_ready_b !== 1'b1) begin
      nerr++; $display("FAIL corner_end: tx_b=%b s_ready_b=%b required 1 1", tx_b, s_ready_b);
    end
  endtask

  task automatic test_loopback;
    logic [WIN-1:0] sent[$];
    logic [WIN-1:0] d;
    int n;
    rx_q.delete();
    rx_bad_stop = 0;
    rx_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d = 16'($urandom);
      sent.push_back(d);
      hs_a(d);
      n = 0;
      while (!s_ready && n < F + 10) begin @(negedge clk); n++; end
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end
    repeat (F + 10) @(negedge clk);
    rx_en = 1'b0;
    nchk++;
    if (rx_q.size() != sent.size() || rx_bad_stop != 0) begin
      nerr++;
      $display("FAIL loop_count: received=%0d bad_stop=%0d required %0d and 0", rx_q.size(), rx_bad_stop, sent.size());
    end
    for (int i = 0; i < sent.size() && i < rx_q.size(); i++) begin
      nchk++;
      if (rx_q[i] !== sent[i]) begin
        nerr++; $display("FAIL loop_data i=%0d: got=%h required %h", i, rx_q[i], sent[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_corner();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
